// File: rtl/snn_pkg.sv
// Shared types and defaults for the SNN input loader.
// Default geometry matches a 28x28 binary image packed as 98 bytes.
package snn_pkg;

  localparam int DEF_NUM_PIXELS = 784;
  localparam int DEF_ADDR_W     = 10;

  localparam logic [7:0] ASCII_ZERO = 8'h30;

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    UNPACK = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    SEND   = 3'd4
  } loader_state_t;

  // Turn a 0-9 result into the byte handed to the transmitter.
  function automatic logic [7:0] fmt_digit(input logic [3:0] d, input logic ascii);
    if (ascii) fmt_digit = ASCII_ZERO + {4'h0, d};
    else       fmt_digit = {4'h0, d};
  endfunction

endpackage

// File: rtl/snn_rx_fifo2.sv
// Two-entry byte FIFO between the UART receiver and the unpacker.
// A push while full is ignored; the caller accounts for the drop.
module snn_rx_fifo2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  logic [7:0] mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage: no reset needed, contents are only read when the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/snn_input_loader.sv
// Writer-side front end for the SNN input-unit RAM.
// Receives packed pixel bytes, writes them one bit per cycle, starts the core,
// then forwards the classified digit to the UART transmitter.
// Build option: define SNN_LOADER_ASCII_EN to send the digit as ASCII '0'-'9';
// otherwise the raw value {4'h0, digit} is sent.
//
// state  | meaning
// -------+------------------------------------------------------------
// LOAD   | idle between bytes; pop next byte from the FIFO when present
// UNPACK | one RAM write per cycle, 8 cycles per byte
// START  | frame complete: flush stray bytes, pulse core_start
// WAIT   | wait for core_done and latch the digit
// SEND   | wait for the transmitter to be free, issue tx_start
module snn_input_loader
  import snn_pkg::*;
#(
  parameter int NUM_PIXELS = DEF_NUM_PIXELS,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_data,
  output logic              ram_we,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        digit,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  loader_state_t     state;
  loader_state_t     next_state;
  logic [ADDR_W-1:0] cnt;
  logic [7:0]        shift;
  logic [2:0]        idx;
  logic [3:0]        digit_q;
  logic [7:0]        digit_byte;

  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_flush;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;

  logic byte_end;
  logic frame_end;
  logic rx_open;

  logic [ADDR_W-1:0] ram_addr_nxt;
  logic              ram_data_nxt;
  logic              ram_we_nxt;
  logic              core_start_nxt;
  logic              tx_start_nxt;
  logic [7:0]        tx_data_nxt;

`ifdef SNN_LOADER_ASCII_EN
  assign digit_byte = fmt_digit(digit_q, 1'b1);
`else
  assign digit_byte = fmt_digit(digit_q, 1'b0);
`endif

  // Bytes are only accepted while a frame is being loaded.
  assign rx_open    = (state == LOAD) || (state == UNPACK);
  assign fifo_push  = rx_rdy && rx_open && !fifo_full;
  assign byte_end   = (state == UNPACK) && (idx == 3'd7);
  assign frame_end  = byte_end && (cnt == LAST_ADDR);
  // No bypass: a byte pushed into an empty FIFO is popped on the next cycle.
  assign fifo_pop   = !fifo_empty &&
                      ((state == LOAD) || (byte_end && !frame_end));
  assign fifo_flush = (state == START);

  snn_rx_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (rx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      LOAD:    if (!fifo_empty) next_state = UNPACK;
      UNPACK: begin
        if (byte_end) begin
          if (frame_end)       next_state = START;
          else if (fifo_empty) next_state = LOAD;
        end
      end
      START:   next_state = WAIT;
      WAIT:    if (core_done) next_state = SEND;
      SEND:    if (!tx_busy)  next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  // Output decode; values are registered below so every output is a flop.
  always_comb begin
    ram_we_nxt     = (state == UNPACK);
    ram_addr_nxt   = (state == UNPACK) ? cnt : ram_addr;
    ram_data_nxt   = (state == UNPACK) ? shift[idx] : ram_data;
    core_start_nxt = (state == START);
    tx_start_nxt   = (state == SEND) && !tx_busy;
    tx_data_nxt    = tx_start_nxt ? digit_byte : tx_data;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_addr   <= '0;
      ram_data   <= 1'b0;
      ram_we     <= 1'b0;
      core_start <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
    end else begin
      ram_addr   <= ram_addr_nxt;
      ram_data   <= ram_data_nxt;
      ram_we     <= ram_we_nxt;
      core_start <= core_start_nxt;
      tx_start   <= tx_start_nxt;
      tx_data    <= tx_data_nxt;
    end
  end

  // Pixel counter, shift register, digit latch and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      shift   <= 8'h00;
      idx     <= 3'd0;
      digit_q <= 4'h0;
      overrun <= 1'b0;
    end else begin
      if (fifo_pop) begin
        shift <= fifo_dout;
        idx   <= 3'd0;
      end else if (state == UNPACK) begin
        idx <= idx + 3'd1;
      end

      if (state == UNPACK)  cnt <= cnt + ADDR_W'(1);
      else if (tx_start_nxt) cnt <= '0;

      if ((state == WAIT) && core_done) digit_q <= digit;

      // Dropped either at the door (wrong state or full) or by the START flush.
      if ((rx_rdy && !fifo_push) || (fifo_flush && !fifo_empty)) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_snn_input_loader.sv
// Self-checking bench for snn_input_loader with randomized images.
module tb_snn_input_loader;
  import snn_pkg::*;

  localparam int NP = DEF_NUM_PIXELS;
  localparam int NB = NP / 8;
  localparam int AW = DEF_ADDR_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_rdy = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic [AW-1:0] ram_addr;
  logic          ram_data;
  logic          ram_we;
  logic          core_start;
  logic          core_done = 1'b0;
  logic [3:0]    digit = 4'h0;
  logic          tx_busy = 1'b0;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          overrun;

  always #5 clk = ~clk;

  snn_input_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_we     (ram_we),
    .core_start (core_start),
    .core_done  (core_done),
    .digit      (digit),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .overrun    (overrun)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] img [NB];

  // Observed events, sampled on the falling edge.
  int         cyc = 0;
  int         wr_addr_q [$];
  bit         wr_data_q [$];
  int         wr_cyc_q [$];
  int         cs_cnt = 0;
  int         cs_cyc = 0;
  int         tx_cnt = 0;
  logic [7:0] tx_last = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (ram_we) begin
      wr_addr_q.push_back(int'(ram_addr));
      wr_data_q.push_back(ram_data);
      wr_cyc_q.push_back(cyc);
    end
    if (core_start) begin
      cs_cnt++;
      cs_cyc = cyc;
    end
    if (tx_start) begin
      tx_cnt++;
      tx_last = tx_data;
    end
  end

  // Reference: pixel at address a is bit (a mod 8) of byte a/8 of the image.
  function automatic int frame_errs();
    int e = 0;
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      logic [7:0] b;
      b = img[i / 8];
      if (wr_addr_q[i] != i || wr_data_q[i] != b[i % 8]) e++;
    end
    return e;
  endfunction

  function automatic logic [7:0] exp_tx(input int d);
`ifdef SNN_LOADER_ASCII_EN
    return 8'(48 + d);
`else
    return 8'(d);
`endif
  endfunction

  task automatic step(input logic rdy, input logic [7:0] data);
    @(posedge clk);
    #1;
    rx_rdy  = rdy;
    rx_data = data;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    cs_cnt = 0;
    tx_cnt = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    rx_rdy    = 1'b0;
    core_done = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic fill_img(input bit random_fill);
    for (int i = 0; i < NB; i++) img[i] = random_fill ? 8'($urandom) : 8'hA5;
  endtask

  task automatic send_bytes(input int first, input int n, input int gmin, input int gmax);
    for (int i = first; i < first + n; i++) begin
      step(1'b1, img[i]);
      idle(int'($urandom_range(gmax, gmin)));
    end
  endtask

  task automatic wait_cs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cs_cnt > 0) begin
        ok = 1'b1;
        break;
      end
      idle(1);
    end
  endtask

  task automatic give_done(input logic [3:0] d);
    @(posedge clk);
    #1;
    core_done = 1'b1;
    digit     = d;
    @(posedge clk);
    #1;
    core_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [AW+12:0] outs;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    outs = {ram_addr, ram_data, ram_we, core_start, tx_start, tx_data, overrun};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", outs);
    end
    clear_mon();
    give_done(4'd5);
    idle(10);
    total++;
    if (tx_cnt !== 0 || cs_cnt !== 0 || wr_addr_q.size() !== 0) begin
      bad++;
      $display("FAIL idle_done_ignored tx=%0d cs=%0d wr=%0d want=0/0/0", tx_cnt, cs_cnt, wr_addr_q.size());
    end
  endtask

  task automatic test_full_frame();
    bit ok;
    int last_wr;
    clear_mon();
    fill_img(1'b0);
    send_bytes(0, NB, 20, 20);
    wait_cs(ok);
    idle(20);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL full_start_timeout got=none want=core_start");
    end
    total++;
    if (wr_addr_q.size() !== NP) begin
      bad++;
      $display("FAIL full_write_count got=%0d want=%0d", wr_addr_q.size(), NP);
    end
    total++;
    if (frame_errs() !== 0) begin
      bad++;
      $display("FAIL full_write_data got=%0d bad writes want=0", frame_errs());
    end
    total++;
    if (cs_cnt !== 1) begin
      bad++;
      $display("FAIL full_start_count got=%0d want=1", cs_cnt);
    end
    last_wr = (wr_cyc_q.size() > 0) ? wr_cyc_q[$] : -100;
    total++;
    if (cs_cyc !== last_wr + 1) begin
      bad++;
      $display("FAIL full_start_timing got=cycle %0d want=cycle %0d", cs_cyc, last_wr + 1);
    end
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL full_overrun got=%b want=0", overrun);
    end
  endtask

  task automatic test_handoff();
    clear_mon();
    tx_busy = 1'b1;
    give_done(4'd7);
    idle(5);
    total++;
    if (tx_cnt !== 0) begin
      bad++;
      $display("FAIL handoff_busy_hold got=%0d tx_start want=0", tx_cnt);
    end
    tx_busy = 1'b0;
    idle(6);
    total++;
    if (tx_cnt !== 1) begin
      bad++;
      $display("FAIL handoff_tx_count got=%0d want=1", tx_cnt);
    end
    total++;
    if (tx_last !== exp_tx(7)) begin
      bad++;
      $display("FAIL handoff_tx_data got=%h want=%h", tx_last, exp_tx(7));
    end
  endtask

  task automatic test_back_to_back();
    int span;
    do_reset();
    clear_mon();
    fill_img(1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, img[i]);
    idle(40);
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL b2b3_overrun got=%b want=0", overrun);
    end
    total++;
    if (wr_addr_q.size() !== 24) begin
      bad++;
      $display("FAIL b2b3_write_count got=%0d want=24", wr_addr_q.size());
    end
    total++;
    if (frame_errs() !== 0) begin
      bad++;
      $display("FAIL b2b3_write_data got=%0d bad writes want=0", frame_errs());
    end
    span = (wr_cyc_q.size() == 24) ? wr_cyc_q[23] - wr_cyc_q[0] : -1;
    total++;
    if (span !== 23) begin
      bad++;
      $display("FAIL b2b3_gapless got=span %0d want=23", span);
    end

    do_reset();
    clear_mon();
    fill_img(1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, img[i]);
    idle(40);
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL b2b4_overrun got=%b want=1", overrun);
    end
    total++;
    if (wr_addr_q.size() !== 24) begin
      bad++;
      $display("FAIL b2b4_write_count got=%0d want=24", wr_addr_q.size());
    end
    total++;
    if (frame_errs() !== 0) begin
      bad++;
      $display("FAIL b2b4_write_data got=%0d bad writes want=0", frame_errs());
    end
  endtask

  task automatic test_extra_byte();
    bit ok;
    logic [3:0] d;
    do_reset();
    clear_mon();
    fill_img(1'b1);
    send_bytes(0, NB, 7, 12);
    wait_cs(ok);
    idle(3);
    total++;
    if (!ok || overrun !== 1'b0) begin
      bad++;
      $display("FAIL extra_clean_frame got=start %b overrun %b want=1/0", ok, overrun);
    end
    clear_mon();
    step(1'b1, 8'($urandom));
    idle(10);
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL extra_overrun got=%b want=1", overrun);
    end
    total++;
    if (wr_addr_q.size() !== 0) begin
      bad++;
      $display("FAIL extra_no_write got=%0d writes want=0", wr_addr_q.size());
    end
    d = 4'($urandom_range(9, 0));
    give_done(d);
    idle(5);
    total++;
    if (tx_cnt !== 1 || tx_last !== exp_tx(int'(d))) begin
      bad++;
      $display("FAIL extra_tx got=%0d/%h want=1/%h", tx_cnt, tx_last, exp_tx(int'(d)));
    end
    clear_mon();
    fill_img(1'b1);
    send_bytes(0, NB, 7, 12);
    wait_cs(ok);
    idle(3);
    total++;
    if (wr_addr_q.size() !== NP || frame_errs() !== 0) begin
      bad++;
      $display("FAIL extra_next_frame got=%0d writes %0d bad want=%0d/0", wr_addr_q.size(), frame_errs(), NP);
    end
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL extra_overrun_sticky got=%b want=1", overrun);
    end
    give_done(4'd0);
    idle(5);
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    logic [AW+12:0] outs;
    do_reset();
    clear_mon();
    fill_img(1'b1);
    send_bytes(0, 40, 0, 12);
    rx_rdy = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    outs = {ram_addr, ram_data, ram_we, core_start, tx_start, tx_data, overrun};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got=%h want=0", outs);
    end
    clear_mon();
    idle(20);
    total++;
    if (wr_addr_q.size() !== 0 || cs_cnt !== 0 || tx_cnt !== 0) begin
      bad++;
      $display("FAIL midreset_quiet got=wr %0d cs %0d tx %0d want=0", wr_addr_q.size(), cs_cnt, tx_cnt);
    end
    fill_img(1'b1);
    send_bytes(0, NB, 7, 12);
    wait_cs(ok);
    idle(5);
    total++;
    if (wr_addr_q.size() !== NP || frame_errs() !== 0) begin
      bad++;
      $display("FAIL midreset_frame got=%0d writes %0d bad want=%0d/0", wr_addr_q.size(), frame_errs(), NP);
    end
    total++;
    if (cs_cnt !== 1) begin
      bad++;
      $display("FAIL midreset_start got=%0d want=1", cs_cnt);
    end
    give_done(4'd1);
    idle(5);
  endtask

  task automatic test_consecutive_frames();
    bit ok;
    int d;
    for (int f = 0; f < 2; f++) begin
      d = (f == 0) ? 3 : 9;
      clear_mon();
      fill_img(1'b1);
      send_bytes(0, NB, 7, 12);
      wait_cs(ok);
      idle(5);
      total++;
      if (wr_addr_q.size() !== NP || frame_errs() !== 0 || cs_cnt !== 1) begin
        bad++;
        $display("FAIL consec_frame%0d got=%0d writes %0d bad %0d starts want=%0d/0/1", f, wr_addr_q.size(), frame_errs(), cs_cnt, NP);
      end
      give_done(4'(d));
      idle(5);
      total++;
      if (tx_cnt !== 1 || tx_last !== exp_tx(d)) begin
        bad++;
        $display("FAIL consec_tx%0d got=%0d/%h want=1/%h", f, tx_cnt, tx_last, exp_tx(d));
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_handoff();
    test_back_to_back();
    test_extra_byte();
    test_reset_mid_frame();
    test_consecutive_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
